// File: rtl/stopwatch_pkg.sv
// Status encodings shared by the stopwatch control FSM and its command generator.
package stopwatch_pkg;

  typedef logic [1:0] status_t;

  localparam status_t ST_IDLE    = 2'b00;
  localparam status_t ST_RUNNING = 2'b01;
  localparam status_t ST_PAUSED  = 2'b10;

endpackage

// File: rtl/stopwatch_cmd_gen_if.sv
// Button/status inputs and command pulse outputs between the front-end and the stopwatch FSM side.
interface stopwatch_cmd_gen_if;
  import stopwatch_pkg::*;

  logic    btn_ss_raw;
  logic    btn_rst_raw;
  status_t status;
  logic    start;
  logic    stop;
  logic    reset;

  modport master (
    output btn_ss_raw, btn_rst_raw, status,
    input  start, stop, reset
  );

  modport slave (
    input  btn_ss_raw, btn_rst_raw, status,
    output start, stop, reset
  );
endinterface

// File: rtl/btn_debounce.sv
// One button path: 2-flop synchroniser, saturating-free debounce counter, rising-edge detect.
// Debounced level rises DEBOUNCE_CYCLES+1 edges after the first stable-high sample; press is 1 cycle.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int              CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LIMIT) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Turns debounced start/stop and reset buttons into one-cycle start/stop/reset commands, reset wins.
// Outputs registered; optional long-press reset enabled by macro STOPWATCH_CMD_LONGPRESS_EN.
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000
) (
  input logic                clk,
  input logic                rst,
  stopwatch_cmd_gen_if.slave cmd
);

  logic w_ss_level;
  logic w_ss_press;
  logic w_rst_press;
  logic w_rst_level_unused;
  logic w_long_evt;
  logic w_reset_cmd;
  logic w_start_cmd;
  logic w_stop_cmd;
  logic r_start;
  logic r_stop;
  logic r_reset;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (cmd.btn_ss_raw),
    .level (w_ss_level),
    .press (w_ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (cmd.btn_rst_raw),
    .level (w_rst_level_unused),
    .press (w_rst_press)
  );

`ifdef STOPWATCH_CMD_LONGPRESS_EN
  localparam int            LW       = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_HIT = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] r_hold_cnt;

  // Saturates at LONG_CYCLES so the long-press reset fires once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (!w_ss_level) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != HOLD_MAX) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign w_long_evt = w_ss_level && (r_hold_cnt == HOLD_HIT);
`else
  logic w_cfg_unused;

  assign w_long_evt   = 1'b0;
  assign w_cfg_unused = ^{w_ss_level, (LONG_CYCLES > 0)};
`endif

  assign w_reset_cmd = w_rst_press | w_long_evt;

  // A coincident reset drops the start/stop event outright.
  always_comb begin
    w_start_cmd = 1'b0;
    w_stop_cmd  = 1'b0;
    if (w_ss_press && !w_reset_cmd) begin
      case (cmd.status)
        ST_IDLE, ST_PAUSED: w_start_cmd = 1'b1;
        ST_RUNNING:         w_stop_cmd  = 1'b1;
        default:            ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_start <= w_start_cmd;
      r_stop  <= w_stop_cmd;
      r_reset <= w_reset_cmd;
    end
  end

  assign cmd.start = r_start;
  assign cmd.stop  = r_stop;
  assign cmd.reset = r_reset;

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Self-checking bench for stopwatch_cmd_gen: vector table plus hand-written corner sequences.
module tb_stopwatch_cmd_gen;
  import stopwatch_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;

  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_START = 3'b100;
  localparam logic [2:0] C_STOP  = 3'b010;
  localparam logic [2:0] C_RESET = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
  } exp_t;

  typedef struct {
    logic [1:0] st;
    logic       ss;
    logic       rb;
    int         hold;
    logic [2:0] cmd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n;
  exp_t sb[$];
  vec_t vecs[8];
  int   bnc[5];

  stopwatch_cmd_gen_if cmd_if();

  stopwatch_cmd_gen #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd_if)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] outs();
    return {cmd_if.start, cmd_if.stop, cmd_if.reset};
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // Compares any pulse against the scoreboard head; also catches expected pulses that never came.
  task automatic monitor();
    logic [2:0] act;
    exp_t       e;
    act = outs();
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse cyc=%0d expected=%b at cyc %0d got none", cyc, sb[0].cmd, sb[0].cyc);
      sb.delete(0);
    end
    if (act != C_NONE) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b expected=none", cyc, act);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.cmd != act) begin
          failures++;
          $display("FAIL pulse cyc=%0d got=%b expected=%b at cyc %0d", cyc, act, e.cmd, e.cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d expected=0 (first at cyc %0d)", name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic settle(input string name);
    cmd_if.btn_ss_raw  = 1'b0;
    cmd_if.btn_rst_raw = 1'b0;
    repeat (2 * DEB + 6) tick();
    check_empty(name);
  endtask

  initial begin
    vecs[0] = '{ST_IDLE,    1'b1, 1'b0, 10, C_START};
    vecs[1] = '{ST_PAUSED,  1'b1, 1'b0, 50, C_START};
    vecs[2] = '{ST_RUNNING, 1'b1, 1'b0, 10, C_STOP};
    vecs[3] = '{2'b11,      1'b1, 1'b0, 10, C_NONE};
    vecs[4] = '{ST_RUNNING, 1'b0, 1'b1, 10, C_RESET};
    vecs[5] = '{2'b11,      1'b0, 1'b1, 10, C_RESET};
    vecs[6] = '{ST_RUNNING, 1'b1, 1'b1, 12, C_RESET};
    vecs[7] = '{ST_IDLE,    1'b1, 1'b1, 10, C_RESET};
    bnc     = '{1, 0, 1, 1, 0};

    cmd_if.btn_ss_raw  = 1'b0;
    cmd_if.btn_rst_raw = 1'b0;
    cmd_if.status      = ST_IDLE;
    rst                = 1'b1;
    repeat (3) tick();
    chk("reset_state", outs(), C_NONE);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      cmd_if.status      = vecs[i].st;
      cmd_if.btn_ss_raw  = vecs[i].ss;
      cmd_if.btn_rst_raw = vecs[i].rb;
      if (vecs[i].cmd != C_NONE) sb.push_back('{cyc + LAT, vecs[i].cmd});
      repeat (vecs[i].hold) tick();
      settle($sformatf("vec%0d_done", i));
    end

    // Bounce shorter than the debounce window, then a clean hold.
    cmd_if.status = ST_RUNNING;
    for (int i = 0; i < 5; i++) begin
      cmd_if.btn_ss_raw = bnc[i][0];
      tick();
    end
    cmd_if.btn_ss_raw = 1'b1;
    sb.push_back('{cyc + LAT, C_STOP});
    repeat (15) tick();
    settle("bounce_done");

    // rst asserted while a start pulse is high must clear it immediately.
    cmd_if.status     = ST_IDLE;
    cmd_if.btn_ss_raw = 1'b1;
    repeat (LAT - 1) tick();
    @(posedge clk);
    cyc++;
    #1;
    chk("live_pulse", outs(), C_START);
    rst = 1'b1;
    #1;
    chk("async_clear", outs(), C_NONE);
    @(negedge clk);
    cmd_if.btn_ss_raw = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    settle("async_clear_done");

    // rst mid-debounce: partial press discarded, held button fires fresh after release.
    cmd_if.status     = ST_IDLE;
    cmd_if.btn_ss_raw = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_debounce_outs", outs(), C_NONE);
    repeat (2) tick();
    rst = 1'b0;
    sb.push_back('{cyc + LAT, C_START});
    repeat (12) tick();
    settle("rst_mid_debounce_done");

    // Long hold while running.
    cmd_if.status     = ST_RUNNING;
    cmd_if.btn_ss_raw = 1'b1;
    n = cyc;
    sb.push_back('{n + LAT, C_STOP});
`ifdef STOPWATCH_CMD_LONGPRESS_EN
    sb.push_back('{n + DEB + 2 + LONG, C_RESET});
`endif
    repeat (40) tick();
    settle("long_hold_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_cmd_gen.md
# stopwatch_cmd_gen

Front-end command generator for the stopwatch control FSM. Converts two raw, asynchronous push-buttons (start/stop toggle and reset) into single-cycle `start`, `stop` and `reset` command pulses for the FSM. It reads the FSM's `status` back so that one toggle button can issue either `start` or `stop`. Each button path is synchronised, debounced and edge-detected.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synced cycles a button must differ from its debounced value before that value flips. Must be ≥1.
- `LONG_CYCLES`, default 100000000: hold length for a long-press reset. Used only when the long-press macro is defined.
- `clk`  in  1  system clock; all flops on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_ss_raw`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_rst_raw`  in  1  raw reset button, active-high, asynchronous to `clk`.
- `status`  in  2  FSM state: 00 idle, 01 running, 10 paused, 11 illegal.
- `start`  out  1  one-cycle command pulse to the FSM.
- `stop`  out  1  one-cycle command pulse to the FSM.
- `reset`  out  1  one-cycle command pulse to the FSM. This is the FSM command, not a block reset.

## Operation
- **Per-button path:** 2-flop synchroniser, then debounce counter, then rising-edge detect on the debounced level.
- **Debounce:**
  - While the synced value ≠ debounced value, the counter increments.
  - Any cycle with synced value = debounced value clears the counter to 0.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
  - Release is debounced identically; a release generates no event.
- **Press event:** a 0→1 transition of the debounced level, valid for exactly one cycle.
- **Start/stop press decode, using `status` sampled in the same cycle:**
  - idle → `start`
  - paused → `start`
  - running → `stop`
  - 11 → nothing
- **Reset press:** always produces `reset`, regardless of `status`.
- **Simultaneous events:** a reset event and a start/stop event in the same cycle produce `reset` only; the start/stop event is dropped, not deferred.
- **Mutual exclusion:** at most one of `start`/`stop`/`reset` is high in any cycle.
- **Reset (`rst`):**
  - Clears synchroniser flops, debounced levels, counters, the long-press state and all outputs to 0.
  - Reset value of every output is 0.
  - If a button is held while `rst` is released, it is seen as a fresh press and fires after normal debounce latency.
- **Reset mid-debounce:** `rst` discards the partial count; no pulse is produced for that press.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES+1)` bits. The counter never wraps, because it clears on reaching the limit.

## Timing
- All outputs are registered.
- **Latency:** raw input sampled stable high first at edge E. The debounced level rises after edge E+1+`DEBOUNCE_CYCLES`. The command pulse is high for the cycle after edge E+2+`DEBOUNCE_CYCLES`.
- **Pulse width:** exactly 1 cycle per press, however long the button is held.
- **Minimum press-to-press spacing:** 2·`DEBOUNCE_CYCLES` + 2 cycles (press + release).
- **Bounce rejection:** glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.

## Configuration
- **Macro `STOPWATCH_CMD_LONGPRESS_EN`:**
  - **Defined:** a hold counter runs while the debounced start/stop level is high.
    - When it reaches `LONG_CYCLES`, `reset` pulses once, then the counter saturates until release. Release clears it.
    - The normal `start`/`stop` pulse at the press still occurs.
    - If the long-press `reset` coincides with a reset-button event, a single `reset` pulse is produced.
  - **Undefined:** no hold counter is built, `LONG_CYCLES` is unused, and holding the button has no effect beyond the initial press.

## Structure
- **Shared package `stopwatch_pkg`:** status encodings `ST_IDLE`=2'b00, `ST_RUNNING`=2'b01, `ST_PAUSED`=2'b10, and the 2-bit status type. The control FSM uses the same package.
- **Sub-module `btn_debounce`:** synchroniser + debounce + rise detect.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst`, `raw`, `level`, `press`.
  - Instantiated twice.
- The top level holds the decode, priority, output registers and the optional long-press counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=20.
1. **Clean start from idle:** `btn_ss_raw` 0→1 at edge E, `status`=00. Expect `start`=1 for exactly the cycle after edge E+6; `stop`/`reset` stay 0.
2. **Bounce rejection:** `btn_ss_raw` toggles 1,0,1,1,0 over 5 cycles, then held high, `status`=01. Expect no pulse during the bounce, then a single `stop` 6 edges after the final rise.
3. **Toggle decode:**
   - Press with `status`=10 → `start`.
   - Press with `status`=11 → no pulse.
   - Holding the button 50 cycles → no extra pulses.
4. **Simultaneous events:** both raw buttons rise at the same edge, `status`=01. Expect `reset` only; `stop` never asserts.
5. **Async reset mid-debounce:** assert `rst` 2 cycles after the raw rise.
   - Outputs go to 0 immediately.
   - No pulse is produced for that press.
   - Raw still held at `rst` release → `start` fires after full latency.
6. **Long-press (`STOPWATCH_CMD_LONGPRESS_EN` defined):** hold start/stop 40 cycles with `status`=01. Expect `stop` at press, then exactly one `reset` 20 cycles after the debounced rise. With the macro undefined, only the `stop` pulse occurs.
